// File: rtl/l1_mem_arbiter.sv
// Shares one lower-memory port between the I-cache (requester 0) and D-cache (requester 1).
// Round-robin grant, latched downstream request, one-cycle ready pulse, watchdog on hung accesses.
module l1_mem_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  r0_mem_request,
    input  logic [ADDR_WIDTH-1:0] r0_mem_address,
    input  logic                  r0_mem_write_enable,
    input  logic [DATA_WIDTH-1:0] r0_mem_write_data,
    output logic [DATA_WIDTH-1:0] r0_mem_response_data,
    output logic                  r0_mem_ready,

    input  logic                  r1_mem_request,
    input  logic [ADDR_WIDTH-1:0] r1_mem_address,
    input  logic                  r1_mem_write_enable,
    input  logic [DATA_WIDTH-1:0] r1_mem_write_data,
    output logic [DATA_WIDTH-1:0] r1_mem_response_data,
    output logic                  r1_mem_ready,

    output logic                  mem_request,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_write_enable,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    input  logic [DATA_WIDTH-1:0] mem_response_data,
    input  logic                  mem_ready,

    output logic                  grant_owner,
    output logic                  busy,
    output logic                  timeout_error
);

    // A disabled watchdog still keeps a 1-bit counter so no zero-width vectors appear.
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW:0] TIMEOUT_VAL = (CW + 1)'(TIMEOUT_CYCLES);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ISSUE   = 2'd1;
    localparam logic [1:0] RESPOND = 2'd2;

    logic [1:0]            state;
    logic                  last_grant;
    logic [CW-1:0]         wd_cnt;

    logic                  any_request;
    logic                  winner;
    logic [CW:0]           wd_next;
    logic                  wd_expire;
    logic                  issue_done;
    logic [DATA_WIDTH-1:0] resp_val;

    // On a tie the requester that did not win last time is served.
    always_comb begin
        any_request = r0_mem_request | r1_mem_request;
        winner      = 1'b0;
        if (r0_mem_request && r1_mem_request) begin
            winner = ~last_grant;
        end else if (r1_mem_request) begin
            winner = 1'b1;
        end
    end

    // wd_next counts the current ISSUE cycle; expiry on the TIMEOUT_CYCLES-th one.
    always_comb begin
        wd_next    = {1'b0, wd_cnt} + (CW + 1)'(1);
        wd_expire  = (TIMEOUT_CYCLES != 0) && (wd_next == TIMEOUT_VAL);
        issue_done = (state == ISSUE) && (mem_ready || wd_expire);
        resp_val   = mem_ready ? mem_response_data : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            grant_owner <= 1'b0;
            busy        <= 1'b0;
            wd_cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_request) begin
                        grant_owner <= winner;
                        last_grant  <= winner;
                        wd_cnt      <= '0;
                        busy        <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (issue_done) begin
                        state <= RESPOND;
                    end else if (!(&wd_cnt)) begin
                        wd_cnt <= wd_cnt + CW'(1);
                    end
                end
                RESPOND: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Downstream request fields are captured once at grant and held through ISSUE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_request      <= 1'b0;
            mem_address      <= '0;
            mem_write_enable <= 1'b0;
            mem_write_data   <= '0;
        end else if (state == IDLE && any_request) begin
            mem_request      <= 1'b1;
            mem_address      <= winner ? r1_mem_address      : r0_mem_address;
            mem_write_enable <= winner ? r1_mem_write_enable : r0_mem_write_enable;
            mem_write_data   <= winner ? r1_mem_write_data   : r0_mem_write_data;
        end else if (issue_done || state != ISSUE) begin
            mem_request      <= 1'b0;
        end
    end

    // A real mem_ready beats a same-cycle watchdog expiry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r0_mem_ready         <= 1'b0;
            r1_mem_ready         <= 1'b0;
            r0_mem_response_data <= '0;
            r1_mem_response_data <= '0;
            timeout_error        <= 1'b0;
        end else begin
            r0_mem_ready <= 1'b0;
            r1_mem_ready <= 1'b0;
            if (issue_done) begin
                if (grant_owner) begin
                    r1_mem_ready         <= 1'b1;
                    r1_mem_response_data <= resp_val;
                end else begin
                    r0_mem_ready         <= 1'b1;
                    r0_mem_response_data <= resp_val;
                end
                if (!mem_ready) begin
                    timeout_error <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_l1_mem_arbiter.sv
// Directed bench for l1_mem_arbiter with an 8-cycle watchdog.
module tb_l1_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        r0_mem_request, r0_mem_write_enable, r0_mem_ready;
    logic [31:0] r0_mem_address, r0_mem_write_data, r0_mem_response_data;
    logic        r1_mem_request, r1_mem_write_enable, r1_mem_ready;
    logic [31:0] r1_mem_address, r1_mem_write_data, r1_mem_response_data;
    logic        mem_request, mem_write_enable, mem_ready;
    logic [31:0] mem_address, mem_write_data, mem_response_data;
    logic        grant_owner, busy, timeout_error;

    int checks = 0;
    int errors = 0;

    l1_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .r0_mem_request(r0_mem_request), .r0_mem_address(r0_mem_address),
        .r0_mem_write_enable(r0_mem_write_enable), .r0_mem_write_data(r0_mem_write_data),
        .r0_mem_response_data(r0_mem_response_data), .r0_mem_ready(r0_mem_ready),
        .r1_mem_request(r1_mem_request), .r1_mem_address(r1_mem_address),
        .r1_mem_write_enable(r1_mem_write_enable), .r1_mem_write_data(r1_mem_write_data),
        .r1_mem_response_data(r1_mem_response_data), .r1_mem_ready(r1_mem_ready),
        .mem_request(mem_request), .mem_address(mem_address),
        .mem_write_enable(mem_write_enable), .mem_write_data(mem_write_data),
        .mem_response_data(mem_response_data), .mem_ready(mem_ready),
        .grant_owner(grant_owner), .busy(busy), .timeout_error(timeout_error)
    );

    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        r0_mem_request = 0; r0_mem_address = 0; r0_mem_write_enable = 0; r0_mem_write_data = 0;
        r1_mem_request = 0; r1_mem_address = 0; r1_mem_write_enable = 0; r1_mem_write_data = 0;
        mem_ready = 0; mem_response_data = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (mem_request !== 1'b0) begin errors++; $display("FAIL rst_mem_request got %0h exp 0", mem_request); end
        checks++; if (mem_address !== 32'h0) begin errors++; $display("FAIL rst_mem_address got %h exp 0", mem_address); end
        checks++; if (grant_owner !== 1'b0) begin errors++; $display("FAIL rst_grant_owner got %0h exp 0", grant_owner); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %0h exp 0", busy); end
        checks++; if ({r0_mem_ready, r1_mem_ready, timeout_error} !== 3'b000) begin errors++; $display("FAIL rst_flags got %b exp 000", {r0_mem_ready, r1_mem_ready, timeout_error}); end
    endtask

    task automatic test_single_read();
        r0_mem_request = 1; r0_mem_address = 32'h40;
        tick();
        checks++; if (mem_request !== 1'b1) begin errors++; $display("FAIL rd_mem_request got %0h exp 1", mem_request); end
        checks++; if (mem_address !== 32'h40) begin errors++; $display("FAIL rd_mem_address got %h exp 00000040", mem_address); end
        checks++; if (mem_write_enable !== 1'b0) begin errors++; $display("FAIL rd_write_enable got %0h exp 0", mem_write_enable); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rd_busy got %0h exp 1", busy); end
        tick();
        tick();
        mem_ready = 1; mem_response_data = 32'hDEADBEEF;
        tick();
        mem_ready = 0; mem_response_data = 0;
        checks++; if (r0_mem_ready !== 1'b1) begin errors++; $display("FAIL rd_r0_ready got %0h exp 1", r0_mem_ready); end
        checks++; if (r0_mem_response_data !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_r0_data got %h exp deadbeef", r0_mem_response_data); end
        checks++; if (mem_request !== 1'b0) begin errors++; $display("FAIL rd_req_drop got %0h exp 0", mem_request); end
        checks++; if ({r1_mem_ready, r1_mem_response_data} !== 33'h0) begin errors++; $display("FAIL rd_r1_untouched got %0h/%h exp 0/0", r1_mem_ready, r1_mem_response_data); end
        r0_mem_request = 0;
        tick();
        checks++; if ({r0_mem_ready, busy} !== 2'b00) begin errors++; $display("FAIL rd_pulse_end got %b exp 00", {r0_mem_ready, busy}); end
    endtask

    task automatic test_tie();
        do_reset();
        r0_mem_request = 1; r0_mem_address = 32'h100;
        r1_mem_request = 1; r1_mem_address = 32'h200;
        tick();
        checks++; if ({grant_owner, mem_address} !== {1'b0, 32'h100}) begin errors++; $display("FAIL tie1_grant got %0h/%h exp 0/00000100", grant_owner, mem_address); end
        mem_ready = 1; mem_response_data = 32'h111;
        tick();
        mem_ready = 0;
        checks++; if ({r0_mem_ready, r1_mem_ready} !== 2'b10) begin errors++; $display("FAIL tie1_ready got %b exp 10", {r0_mem_ready, r1_mem_ready}); end
        r0_mem_request = 0;
        tick();
        checks++; if (mem_request !== 1'b0) begin errors++; $display("FAIL tie_gap got %0h exp 0", mem_request); end
        tick();
        checks++; if ({grant_owner, mem_address} !== {1'b1, 32'h200}) begin errors++; $display("FAIL tie2_grant got %0h/%h exp 1/00000200", grant_owner, mem_address); end
        mem_ready = 1; mem_response_data = 32'h222;
        tick();
        mem_ready = 0;
        checks++; if ({r0_mem_ready, r1_mem_ready} !== 2'b01) begin errors++; $display("FAIL tie2_ready got %b exp 01", {r0_mem_ready, r1_mem_ready}); end
        checks++; if ({r0_mem_response_data, r1_mem_response_data} !== {32'h111, 32'h222}) begin errors++; $display("FAIL tie_data got %h/%h exp 00000111/00000222", r0_mem_response_data, r1_mem_response_data); end
        r1_mem_request = 0;
        tick();
        r0_mem_request = 1; r1_mem_request = 1;
        tick();
        checks++; if ({grant_owner, mem_address} !== {1'b0, 32'h100}) begin errors++; $display("FAIL tie3_grant got %0h/%h exp 0/00000100", grant_owner, mem_address); end
        mem_ready = 1; mem_response_data = 32'h333;
        tick();
        mem_ready = 0;
        r0_mem_request = 0; r1_mem_request = 0;
        tick();
    endtask

    task automatic test_write();
        r1_mem_request = 1; r1_mem_address = 32'h80;
        r1_mem_write_enable = 1; r1_mem_write_data = 32'hCAFE0001;
        tick();
        checks++; if ({mem_request, mem_write_enable, grant_owner} !== 3'b111) begin errors++; $display("FAIL wr_ctrl got %b exp 111", {mem_request, mem_write_enable, grant_owner}); end
        checks++; if (mem_write_data !== 32'hCAFE0001) begin errors++; $display("FAIL wr_data got %h exp cafe0001", mem_write_data); end
        r1_mem_address = 32'hFFF0; r1_mem_write_data = 32'h5555AAAA;
        tick();
        checks++; if (mem_address !== 32'h80) begin errors++; $display("FAIL wr_addr_hold got %h exp 00000080", mem_address); end
        checks++; if (mem_write_data !== 32'hCAFE0001) begin errors++; $display("FAIL wr_data_hold got %h exp cafe0001", mem_write_data); end
        mem_ready = 1; mem_response_data = 32'h0;
        tick();
        mem_ready = 0;
        checks++; if ({r0_mem_ready, r1_mem_ready} !== 2'b01) begin errors++; $display("FAIL wr_ready got %b exp 01", {r0_mem_ready, r1_mem_ready}); end
        clear_inputs();
        tick();
    endtask

    task automatic test_timeout_race();
        do_reset();
        r0_mem_request = 1; r0_mem_address = 32'h300;
        for (int i = 1; i < 8; i++) tick();
        tick();
        checks++; if (mem_request !== 1'b1) begin errors++; $display("FAIL race_issue8 got %0h exp 1", mem_request); end
        mem_ready = 1; mem_response_data = 32'h12345678;
        tick();
        mem_ready = 0;
        checks++; if ({r0_mem_ready, r0_mem_response_data} !== {1'b1, 32'h12345678}) begin errors++; $display("FAIL race_resp got %0h/%h exp 1/12345678", r0_mem_ready, r0_mem_response_data); end
        checks++; if (timeout_error !== 1'b0) begin errors++; $display("FAIL race_no_error got %0h exp 0", timeout_error); end
        r0_mem_request = 0;
        tick();
    endtask

    task automatic test_timeout();
        r0_mem_request = 1; r0_mem_address = 32'h304;
        for (int i = 1; i <= 8; i++) tick();
        checks++; if (mem_request !== 1'b1) begin errors++; $display("FAIL to_issue8 got %0h exp 1", mem_request); end
        tick();
        checks++; if (mem_request !== 1'b0) begin errors++; $display("FAIL to_req_drop got %0h exp 0", mem_request); end
        checks++; if ({r0_mem_ready, r0_mem_response_data} !== {1'b1, 32'h0}) begin errors++; $display("FAIL to_resp got %0h/%h exp 1/00000000", r0_mem_ready, r0_mem_response_data); end
        checks++; if (timeout_error !== 1'b1) begin errors++; $display("FAIL to_error got %0h exp 1", timeout_error); end
        r0_mem_request = 0;
        tick();
        tick();
        checks++; if ({timeout_error, busy, r0_mem_ready} !== 3'b100) begin errors++; $display("FAIL to_sticky got %b exp 100", {timeout_error, busy, r0_mem_ready}); end
        do_reset();
        checks++; if (timeout_error !== 1'b0) begin errors++; $display("FAIL to_clear got %0h exp 0", timeout_error); end
    endtask

    task automatic test_reset_stray();
        r1_mem_request = 1; r1_mem_address = 32'h500;
        tick();
        tick();
        rst = 1'b1;
        #1;
        checks++; if ({mem_request, busy, grant_owner} !== 3'b000) begin errors++; $display("FAIL mid_rst_ctrl got %b exp 000", {mem_request, busy, grant_owner}); end
        checks++; if (mem_address !== 32'h0) begin errors++; $display("FAIL mid_rst_addr got %h exp 0", mem_address); end
        r1_mem_request = 0;
        tick();
        rst = 1'b0;
        mem_ready = 1; mem_response_data = 32'hBAD0BAD0;
        tick();
        mem_ready = 0;
        tick();
        checks++; if ({r0_mem_ready, r1_mem_ready, busy} !== 3'b000) begin errors++; $display("FAIL stray_after_rst got %b exp 000", {r0_mem_ready, r1_mem_ready, busy}); end
        checks++; if (r1_mem_response_data !== 32'h0) begin errors++; $display("FAIL stray_rst_data got %h exp 0", r1_mem_response_data); end
        mem_ready = 1; mem_response_data = 32'h0BADF00D;
        tick();
        mem_ready = 0;
        tick();
        checks++; if ({r0_mem_ready, r1_mem_ready, mem_request} !== 3'b000) begin errors++; $display("FAIL stray_idle got %b exp 000", {r0_mem_ready, r1_mem_ready, mem_request}); end
        checks++; if ({r0_mem_response_data, r1_mem_response_data} !== 64'h0) begin errors++; $display("FAIL stray_idle_data got %h/%h exp 0/0", r0_mem_response_data, r1_mem_response_data); end
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        #2;
        test_reset();
        test_single_read();
        test_tie();
        test_write();
        test_timeout_race();
        test_timeout();
        test_reset_stray();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/l1_mem_arbiter.md
# l1_mem_arbiter

Arbiter that shares the single lower-memory port between the L1 instruction cache (requester 0) and the L1 data cache (requester 1). Each cache drives its normal memory-side handshake: a level `mem_request` held until `mem_ready`. The arbiter grants one requester at a time with round-robin fairness, forwards the latched request downstream, and returns the response as a one-cycle ready pulse. A watchdog turns a hung memory access into a completed, flagged response so neither cache stalls forever.

## Interface
- `ADDR_WIDTH`, 32, address width.
- `DATA_WIDTH`, 32, data width.
- `TIMEOUT_CYCLES`, 255, maximum number of cycles the block waits in ISSUE for `mem_ready`; 0 disables the watchdog.

Ports:
- `clk` in 1: the only clock; all logic is on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `r0_mem_request` in 1: I-cache request; held high until it sees `r0_mem_ready`.
- `r0_mem_address` in ADDR_WIDTH: I-cache request address.
- `r0_mem_write_enable` in 1: I-cache write flag.
- `r0_mem_write_data` in DATA_WIDTH: I-cache write data.
- `r0_mem_response_data` out DATA_WIDTH: response data returned to the I-cache.
- `r0_mem_ready` out 1: one-cycle completion pulse to the I-cache.
- `r1_*` ports: identical set of six for the D-cache.
- `mem_request` out 1: request to lower memory.
- `mem_address` out ADDR_WIDTH: address to lower memory.
- `mem_write_enable` out 1: write flag to lower memory.
- `mem_write_data` out DATA_WIDTH: write data to lower memory.
- `mem_response_data` in DATA_WIDTH: lower-memory read data.
- `mem_ready` in 1: lower-memory completion, valid for one cycle.
- `grant_owner` out 1: requester currently or last granted.
- `busy` out 1: high in ISSUE and RESPOND.
- `timeout_error` out 1: sticky; cleared only by `rst`.

## Operation
- FSM states: IDLE, ISSUE, RESPOND. All outputs are registered.
- **IDLE**
  - If any `rX_mem_request` is high, pick a winner.
  - If both are high, the winner is the requester not equal to `last_grant`.
  - Latch the winner's address, write_enable and write_data. Set `grant_owner` and `last_grant`, clear the watchdog counter, and go to ISSUE.
- **ISSUE**
  - `mem_request` = 1. `mem_address`, `mem_write_enable` and `mem_write_data` come from the latched values and do not change even if requester inputs change.
  - Each cycle without `mem_ready`, the counter increments.
  - On `mem_ready`: capture `mem_response_data` into the owner's response register and go to RESPOND.
  - If the counter reaches `TIMEOUT_CYCLES` (when nonzero) without `mem_ready`: load 0 into the owner's response register, set `timeout_error`, and go to RESPOND.
  - If `mem_ready` arrives on the same cycle as the timeout, `mem_ready` wins: data is captured and no error is raised.
- **RESPOND**
  - `mem_request` = 0. The owner's `rX_mem_ready` = 1 for exactly this cycle.
  - Next state is always IDLE. This one-cycle turnaround lets the requester drop its request before IDLE re-samples it.
- **Other rules**
  - `mem_ready` outside ISSUE is ignored.
  - The non-owner's ready stays 0. Each `rX_mem_response_data` holds its value until that requester's next RESPOND.
  - Counter width: `$clog2(TIMEOUT_CYCLES+1)`. It saturates and never wraps.
- **Reset values**
  - State IDLE, `last_grant` = 1 (so requester 0 wins the first tie).
  - `grant_owner` = 0; all ready, request, write_enable, address and data outputs = 0; `busy` = 0; `timeout_error` = 0.
- **Reset mid-operation:** the transaction is abandoned with no ready pulse. A `mem_ready` arriving after reset is ignored because the state is IDLE.

## Timing
- A request first seen high in cycle N gives `mem_request` = 1 in cycle N+1.
- If `mem_ready` arrives in cycle M (M ≥ N+1), `rX_mem_ready` = 1 in cycle M+1 and the FSM is in IDLE in cycle M+2.
- Minimum latency from request to ready: 2 cycles. Minimum gap between two grants: 3 cycles.
- With both requesters continuously requesting, grants strictly alternate.
- A timeout fires after exactly `TIMEOUT_CYCLES` ISSUE cycles. The ready pulse follows one cycle later.

## Test plan
- **Single read:** `r0_mem_request` high with address 0x0000_0040; memory asserts `mem_ready` with 0xDEADBEEF 2 cycles after `mem_request` rises → `mem_address` = 0x40, `mem_write_enable` = 0, `r0_mem_ready` pulses for 1 cycle, `r0_mem_response_data` = 0xDEADBEEF, r1 outputs unchanged.
- **Tie after reset:** both requests high in the same cycle, r0 address 0x100, r1 address 0x200 → r0 is served first, then r1. On the next simultaneous request r0 wins again (because `last_grant` = 1).
- **Write:** r1 writes address 0x80 with data 0xCAFE0001 → `mem_write_enable` = 1 and `mem_write_data` = 0xCAFE0001. Changing `r1_mem_address` mid-ISSUE does not change `mem_address`.
- **Timeout:** `TIMEOUT_CYCLES` = 8 and memory never ready → `mem_request` drops after 8 ISSUE cycles, `r0_mem_ready` pulses with data 0, and `timeout_error` = 1 until `rst`.
- **Timeout race:** `mem_ready` with 0x12345678 on the 8th ISSUE cycle → data is delivered and `timeout_error` stays 0.
- **Reset and stray ready:** assert `rst` mid-ISSUE → all outputs are 0 immediately, and a later `mem_ready` produces no ready pulse. Separately, `mem_ready` pulsed while in IDLE → no effect.
